mem_stage_ctrl: RTL and testbench

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

---
 rtl/mem_stage_pkg.sv | 26 ++
 rtl/load_align.sv | 29 ++
 rtl/mem_stage_ctrl.sv | 177 +++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared size encodings, FSM states and byte-enable helper for the MEM stage
package mem_stage_pkg;

    localparam logic [1:0] SZ_NONE = 2'b00;
    localparam logic [1:0] SZ_WORD = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_BYTE = 2'b11;

    localparam int TIMEOUT_CYCLES = 255;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    // Lane k covers bits [8k+7:8k]; halfwords are only ever at offset 0 or 2 here.
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_WORD: byte_en = 4'b1111;
            SZ_HALF: byte_en = off[1] ? 4'b1100 : 4'b0011;
            SZ_BYTE: byte_en = 4'b0001 << off;
            default: byte_en = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - selects the addressed load lanes and sign-extends them to 32 bits
module load_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic [31:0] MemRData,
    output logic [31:0] data
);

    logic [15:0] w_half;
    logic [7:0]  w_byte;

    always_comb begin
        w_half = offset[1] ? MemRData[31:16] : MemRData[15:0];
        case (offset)
            2'd0:    w_byte = MemRData[7:0];
            2'd1:    w_byte = MemRData[15:8];
            2'd2:    w_byte = MemRData[23:16];
            default: w_byte = MemRData[31:24];
        endcase
        case (size)
            SZ_HALF: data = {{16{w_half[15]}}, w_half};
            SZ_BYTE: data = {{24{w_byte[7]}}, w_byte};
            default: data = MemRData;
        endcase
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - MEM stage: data-memory handshake, stall, redirect and MEM/WB register
// Optional bus timeout enabled with `define MEM_TIMEOUT_EN.
module mem_stage_ctrl
    import mem_stage_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst,
    input  logic        MemToReg,
    input  logic        RegWrite,
    input  logic        Branch,
    input  logic        Zero,
    input  logic        Jump,
    input  logic [1:0]  MemRead,
    input  logic [1:0]  MemWrite,
    input  logic [31:0] RegData2,
    input  logic [31:0] ALUResult,
    input  logic [31:0] AdderResult,
    input  logic [4:0]  R_destination,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    output logic [3:0]  MemByteEn,
    input  logic        MemAck,
    input  logic [31:0] MemRData,
    output logic        Stall,
    output logic        PCSrc,
    output logic [31:0] BranchTarget,
    output logic        AlignErr,
    output logic        BusErr,
    output logic        MemToReg_out,
    output logic        RegWrite_out,
    output logic [31:0] ReadData_out,
    output logic [31:0] ALUResult_out,
    output logic [4:0]  R_destination_out
);

    state_t      r_state;
    state_t      w_next_state;
    logic        w_is_wr;
    logic [1:0]  w_size;
    logic [1:0]  w_off;
    logic        w_acc;
    logic        w_misalign;
    logic        w_start;
    logic        w_done;
    logic        w_timeout;
    logic [31:0] w_wdata;
    logic [31:0] w_load_data;
    logic [1:0]  r_size;
    logic [1:0]  r_off;
    logic        r_rd;

    // A store wins over a load when both size fields are non-zero.
    assign w_is_wr    = (MemWrite != SZ_NONE);
    assign w_size     = w_is_wr ? MemWrite : MemRead;
    assign w_off      = ALUResult[1:0];
    assign w_acc      = (w_size != SZ_NONE);
    assign w_misalign = ((w_size == SZ_WORD) && (w_off != 2'b00)) ||
                        ((w_size == SZ_HALF) && w_off[0]);
    assign w_start    = (r_state == ST_IDLE) && w_acc && !w_misalign;
    assign w_done     = (r_state == ST_ACCESS) && (MemAck || w_timeout);

    always_comb begin
        case (w_size)
            SZ_HALF: w_wdata = {2{RegData2[15:0]}};
            SZ_BYTE: w_wdata = {4{RegData2[7:0]}};
            default: w_wdata = RegData2;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    logic [7:0] r_cnt;
    logic       r_bus_err;

    assign w_timeout = (r_state == ST_ACCESS) && !MemAck && (r_cnt == 8'(TIMEOUT_CYCLES - 1));
    assign BusErr    = r_bus_err;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_cnt     <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_bus_err <= w_timeout;
            if ((r_state == ST_ACCESS) && !MemAck && !w_timeout)
                r_cnt <= r_cnt + 8'd1;
            else
                r_cnt <= '0;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign BusErr    = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        Stall        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_next_state = ST_ACCESS;
                    Stall        = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (MemAck || w_timeout) w_next_state = ST_IDLE;
                else                     Stall        = 1'b1;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign PCSrc        = ((Branch && Zero) || Jump) && !Stall;
    assign BranchTarget = AdderResult;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            MemReq    <= 1'b0;
            MemWe     <= 1'b0;
            MemByteEn <= 4'b0000;
            MemAddr   <= '0;
            MemWData  <= '0;
            r_size    <= SZ_NONE;
            r_off     <= 2'b00;
            r_rd      <= 1'b0;
        end else if (w_start) begin
            MemReq    <= 1'b1;
            MemWe     <= w_is_wr;
            MemByteEn <= byte_en(w_size, w_off);
            MemAddr   <= {ALUResult[31:2], 2'b00};
            MemWData  <= w_wdata;
            r_size    <= w_size;
            r_off     <= w_off;
            r_rd      <= !w_is_wr;
        end else if (w_done) begin
            MemReq    <= 1'b0;
            MemWe     <= 1'b0;
            MemByteEn <= 4'b0000;
        end
    end

    load_align u_load_align (
        .size     (r_size),
        .offset   (r_off),
        .MemRData (MemRData),
        .data     (w_load_data)
    );

    // ReadData_out only moves on a genuine load completion, so stray acks leave it intact.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            AlignErr          <= 1'b0;
            MemToReg_out      <= 1'b0;
            RegWrite_out      <= 1'b0;
            ReadData_out      <= '0;
            ALUResult_out     <= '0;
            R_destination_out <= '0;
        end else begin
            AlignErr <= (r_state == ST_IDLE) && w_acc && w_misalign;
            if (!Stall) begin
                MemToReg_out      <= MemToReg;
                RegWrite_out      <= RegWrite && !(w_acc && w_misalign) && !w_timeout;
                ALUResult_out     <= ALUResult;
                R_destination_out <= R_destination;
                if ((r_state == ST_ACCESS) && MemAck && r_rd)
                    ReadData_out <= w_load_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - randomized self-checking bench for mem_stage_ctrl
module tb_mem_stage_ctrl;

    logic        Clk, Rst;
    logic        MemToReg, RegWrite, Branch, Zero, Jump;
    logic [1:0]  MemRead, MemWrite;
    logic [31:0] RegData2, ALUResult, AdderResult;
    logic [4:0]  R_destination;
    logic        MemReq, MemWe;
    logic [31:0] MemAddr, MemWData;
    logic [3:0]  MemByteEn;
    logic        MemAck;
    logic [31:0] MemRData;
    logic        Stall, PCSrc;
    logic [31:0] BranchTarget;
    logic        AlignErr, BusErr;
    logic        MemToReg_out, RegWrite_out;
    logic [31:0] ReadData_out, ALUResult_out;
    logic [4:0]  R_destination_out;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_rdata = 32'h0;

    mem_stage_ctrl dut (
        .Clk(Clk), .Rst(Rst),
        .MemToReg(MemToReg), .RegWrite(RegWrite), .Branch(Branch), .Zero(Zero), .Jump(Jump),
        .MemRead(MemRead), .MemWrite(MemWrite),
        .RegData2(RegData2), .ALUResult(ALUResult), .AdderResult(AdderResult),
        .R_destination(R_destination),
        .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
        .MemByteEn(MemByteEn), .MemAck(MemAck), .MemRData(MemRData),
        .Stall(Stall), .PCSrc(PCSrc), .BranchTarget(BranchTarget),
        .AlignErr(AlignErr), .BusErr(BusErr),
        .MemToReg_out(MemToReg_out), .RegWrite_out(RegWrite_out),
        .ReadData_out(ReadData_out), .ALUResult_out(ALUResult_out),
        .R_destination_out(R_destination_out)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // One instruction through MEM, with the expected behaviour worked out from the access rules.
    task automatic do_instr(input logic [1:0] rd, input logic [1:0] wr, input logic [31:0] addr,
                            input logic [31:0] sdata, input logic [31:0] rdata, input int waits,
                            input logic rw, input logic m2r, input logic br, input logic z,
                            input logic jmp, input logic [31:0] tgt, input logic [4:0] dst,
                            input logic idle_ack);
        int          size, off, stall_cycles;
        logic        is_wr, acc, mis, go, redirect;
        logic [31:0] e_be, e_wd, e_ld, sh;
        is_wr    = (wr != 2'b00);
        size     = is_wr ? int'(wr) : int'(rd);
        off      = int'(addr[1:0]);
        acc      = (size != 0);
        mis      = (size == 1 && off != 0) || (size == 2 && (off % 2) != 0);
        go       = acc && !mis;
        redirect = (br && z) || jmp;
        sh       = rdata >> (8 * off);
        case (size)
            1: begin e_be = 32'hF;      e_wd = sdata; e_ld = rdata; end
            2: begin e_be = 32'h3 << off; e_wd = (sdata & 32'hFFFF) * 32'h0001_0001;
                     e_ld = (sh & 32'hFFFF) >= 32'h8000 ? (sh & 32'hFFFF) - 32'h10000 : (sh & 32'hFFFF); end
            3: begin e_be = 32'h1 << off; e_wd = (sdata & 32'hFF) * 32'h0101_0101;
                     e_ld = (sh & 32'hFF) >= 32'h80 ? (sh & 32'hFF) - 32'h100 : (sh & 32'hFF); end
            default: begin e_be = 32'h0; e_wd = 32'h0; e_ld = 32'h0; end
        endcase

        MemRead = rd; MemWrite = wr; ALUResult = addr; RegData2 = sdata; MemRData = rdata;
        RegWrite = rw; MemToReg = m2r; Branch = br; Zero = z; Jump = jmp;
        AdderResult = tgt; R_destination = dst;
        MemAck = idle_ack && !go;

        @(negedge Clk);
        check_eq("idle_stall", 32'(Stall), 32'(go));
        check_eq("idle_pcsrc", 32'(PCSrc), 32'(redirect && !go));
        check_eq("branch_target", BranchTarget, tgt);
        if (go) begin
            stall_cycles = 1;
            step();
            for (int i = 0; i < waits; i++) begin
                @(negedge Clk);
                check_eq("acc_stall", 32'(Stall), 32'h1);
                check_eq("acc_req", 32'(MemReq), 32'h1);
                check_eq("acc_we", 32'(MemWe), 32'(is_wr));
                check_eq("acc_addr", MemAddr, addr & 32'hFFFF_FFFC);
                check_eq("acc_be", 32'(MemByteEn), e_be);
                if (is_wr) check_eq("acc_wdata", MemWData, e_wd);
                stall_cycles++;
                step();
            end
            MemAck = 1'b1;
            @(negedge Clk);
            check_eq("ack_stall", 32'(Stall), 32'h0);
            check_eq("ack_req", 32'(MemReq), 32'h1);
            check_eq("ack_addr", MemAddr, addr & 32'hFFFF_FFFC);
            check_eq("ack_be", 32'(MemByteEn), e_be);
            check_eq("ack_pcsrc", 32'(PCSrc), 32'(redirect));
            check_eq("stall_cycles", 32'(stall_cycles), 32'(waits + 1));
            step();
            MemAck = 1'b0;
            if (!is_wr) exp_rdata = e_ld;
        end else begin
            step();
            MemAck = 1'b0;
        end
        check_eq("post_req", 32'(MemReq), 32'h0);
        check_eq("post_be", 32'(MemByteEn), 32'h0);
        check_eq("wb_regwrite", 32'(RegWrite_out), 32'(rw && !mis));
        check_eq("wb_memtoreg", 32'(MemToReg_out), 32'(m2r));
        check_eq("wb_alures", ALUResult_out, addr);
        check_eq("wb_dest", 32'(R_destination_out), 32'(dst));
        check_eq("wb_rdata", ReadData_out, exp_rdata);
        check_eq("align_err", 32'(AlignErr), 32'(acc && mis));
    endtask

    initial begin
        int cnt;
        Rst = 1'b1; MemToReg = 0; RegWrite = 0; Branch = 0; Zero = 0; Jump = 0;
        MemRead = 0; MemWrite = 0; RegData2 = 0; ALUResult = 0; AdderResult = 0;
        R_destination = 0; MemAck = 0; MemRData = 0;
        repeat (3) step();
        @(negedge Clk);
        check_eq("rst_req", 32'(MemReq), 32'h0);
        check_eq("rst_we", 32'(MemWe), 32'h0);
        check_eq("rst_be", 32'(MemByteEn), 32'h0);
        check_eq("rst_stall", 32'(Stall), 32'h0);
        check_eq("rst_errs", {30'b0, AlignErr, BusErr}, 32'h0);
        check_eq("rst_wb", {31'b0, RegWrite_out} | ReadData_out | ALUResult_out, 32'h0);
        Rst = 1'b0;
        step();

        do_instr(2'b01, 2'b00, 32'h100, 32'h0, 32'hDEADBEEF, 3, 1, 1, 0, 0, 0, 32'h0, 5'd3, 0);
        do_instr(2'b11, 2'b00, 32'h103, 32'h0, 32'h80000000, 0, 1, 1, 0, 0, 0, 32'h0, 5'd4, 0);
        do_instr(2'b10, 2'b00, 32'h102, 32'h0, 32'h7FFF0000, 1, 1, 1, 0, 0, 0, 32'h0, 5'd5, 0);
        do_instr(2'b00, 2'b11, 32'h201, 32'hAB, 32'h0, 2, 0, 0, 0, 0, 0, 32'h0, 5'd0, 0);
        do_instr(2'b01, 2'b00, 32'h102, 32'h0, 32'h0, 0, 1, 1, 0, 0, 0, 32'h0, 5'd6, 0);
        do_instr(2'b00, 2'b00, 32'h0, 32'h0, 32'h5555AAAA, 0, 0, 0, 1, 1, 0, 32'h400, 5'd0, 1);

        for (int n = 0; n < 150; n++) begin
            do_instr(2'($urandom), ($urandom % 3 == 0) ? 2'($urandom) : 2'b00, $urandom, $urandom,
                     $urandom, int'($urandom_range(0, 4)), 1'($urandom), 1'($urandom),
                     1'($urandom), 1'($urandom), 1'($urandom), $urandom, 5'($urandom), 1'($urandom));
        end

        // Reset in the middle of an access, followed by an ack that belongs to nothing.
        MemRead = 2'b01; MemWrite = 2'b00; ALUResult = 32'h300; RegWrite = 1'b1;
        Branch = 0; Jump = 0;
        step();
        @(negedge Clk);
        check_eq("pre_rst_req", 32'(MemReq), 32'h1);
        Rst = 1'b1; MemRead = 2'b00;
        step();
        Rst = 1'b0;
        exp_rdata = 32'h0;
        check_eq("mid_rst_req", 32'(MemReq), 32'h0);
        check_eq("mid_rst_rdata", ReadData_out, 32'h0);
        check_eq("mid_rst_regwrite", 32'(RegWrite_out), 32'h0);
        @(negedge Clk);
        check_eq("mid_rst_stall", 32'(Stall), 32'h0);
        MemAck = 1'b1; MemRData = 32'h12345678;
        step();
        MemAck = 1'b0;
        check_eq("late_ack_rdata", ReadData_out, exp_rdata);
        check_eq("late_ack_req", 32'(MemReq), 32'h0);

        // Access that is never acknowledged.
        MemRead = 2'b01; ALUResult = 32'h400; RegWrite = 1'b1;
        step();
        cnt = 0;
`ifdef MEM_TIMEOUT_EN
        for (int i = 0; i < 300; i++) begin
            @(negedge Clk);
            if (!Stall) break;
            cnt++;
            step();
        end
        check_eq("timeout_stalled_cycles", 32'(cnt), 32'd254);
        step();
        MemRead = 2'b00;
        check_eq("timeout_buserr", 32'(BusErr), 32'h1);
        check_eq("timeout_req", 32'(MemReq), 32'h0);
        check_eq("timeout_regwrite", 32'(RegWrite_out), 32'h0);
        step();
        check_eq("buserr_pulse", 32'(BusErr), 32'h0);
`else
        for (int i = 0; i < 300; i++) begin
            @(negedge Clk);
            if (Stall && MemReq) cnt++;
            step();
        end
        check_eq("no_timeout_wait", 32'(cnt), 32'd300);
        check_eq("no_buserr", 32'(BusErr), 32'h0);
        MemAck = 1'b1; MemRData = 32'hCAFEF00D;
        step();
        MemAck = 1'b0; MemRead = 2'b00;
        check_eq("long_ack_rdata", ReadData_out, 32'hCAFEF00D);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
